// File: rtl/xs3_pkg.sv
// Shared constants and types for the Excess-3 serial adder.
//   XS3_OFFSET : bias added to every decimal digit in Excess-3 code
//   XS3_MIN/MAX: smallest and largest legal Excess-3 codes (decimal 0 and 9)
//   state_e    : operation tracking state (IDLE between operations, RUN inside one)
package xs3_pkg;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] XS3_MIN    = 4'd3;
  localparam logic [3:0] XS3_MAX    = 4'd12;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/xs3_digit_add.sv
// Combinational single-digit Excess-3 adder with decimal correction.
// Ports:
//   a_i, b_i : Excess-3 operand digits
//   cin_i    : decimal carry in
//   s_o      : Excess-3 sum digit
//   cout_o   : decimal carry out
//   bad_o    : either operand lies outside the legal Excess-3 range
module xs3_digit_add
  import xs3_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o,
  output logic       bad_o
);

  logic [4:0] t;

  // Two biased digits carry a +6 bias, so a decimal carry shows up exactly as
  // a binary carry out of bit 3. Re-bias the low nibble up or down accordingly.
  always_comb begin
    t      = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
    cout_o = t[4];
    s_o    = t[4] ? (t[3:0] + XS3_OFFSET) : (t[3:0] - XS3_OFFSET);
    bad_o  = (a_i < XS3_MIN) || (a_i > XS3_MAX) || (b_i < XS3_MIN) || (b_i > XS3_MAX);
  end

endmodule

// File: rtl/xs3_serial_adder.sv
// Digit-serial Excess-3 adder, least-significant digit first, with a
// valid/ready stream on both sides and one-cycle registered latency.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   in_valid/in_ready   : input handshake for one digit pair
//   a, b                : Excess-3 operand digits
//   first, last         : operation framing on the input beat
//   out_valid/out_ready : output handshake for one sum digit
//   s                   : Excess-3 sum digit
//   s_last              : s is the final digit of its operation
//   cout, err           : final carry and invalid-digit flag, zero unless s_last
module xs3_serial_adder
  import xs3_pkg::*;
#(
  parameter int unsigned MAXDIG = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       first,
  input  logic       last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] s,
  output logic       s_last,
  output logic       cout,
  output logic       err
);

  localparam int unsigned CntW = (MAXDIG > 1) ? $clog2(MAXDIG) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(MAXDIG - 1);

  state_e          state_q, state_d;
  logic            carry_q, carry_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_acc_q, err_acc_d;
  logic            out_valid_q, out_valid_d;
  logic [3:0]      s_q, s_d;
  logic            s_last_q, s_last_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;

  logic            accept;
  logic            op_start;
  logic            cin;
  logic [CntW-1:0] cnt_cur;
  logic            beat_end;
  logic            err_cur;
  logic [3:0]      dig_s;
  logic            dig_cout;
  logic            dig_bad;

  assign in_ready = (!out_valid_q || out_ready) && !rst;
  assign accept   = in_valid && in_ready;

  // A beat starts a fresh operation when nothing is in flight or when it is
  // explicitly marked first; the latter silently abandons the old operation.
  assign op_start = (state_q == IDLE) || first;
  assign cin      = op_start ? 1'b0 : carry_q;
  assign cnt_cur  = op_start ? '0 : cnt_q;
  assign beat_end = last || (cnt_cur == LastCnt);
  assign err_cur  = (!op_start && err_acc_q) || dig_bad;

  xs3_digit_add u_digit_add (
    .a_i    (a),
    .b_i    (b),
    .cin_i  (cin),
    .s_o    (dig_s),
    .cout_o (dig_cout),
    .bad_o  (dig_bad)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = beat_end ? IDLE : RUN;
    end
  end

  // Operation bookkeeping and output register next values.
  always_comb begin
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    err_acc_d   = err_acc_q;
    out_valid_d = out_valid_q;
    s_d         = s_q;
    s_last_d    = s_last_q;
    cout_d      = cout_q;
    err_d       = err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      s_d         = dig_s;
      s_last_d    = beat_end;
      cout_d      = beat_end && dig_cout;
      err_d       = beat_end && err_cur;
      carry_d     = beat_end ? 1'b0 : dig_cout;
      cnt_d       = beat_end ? '0 : cnt_cur + CntW'(1);
      err_acc_d   = beat_end ? 1'b0 : err_cur;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      err_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      s_q         <= 4'd0;
      s_last_q    <= 1'b0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      err_acc_q   <= err_acc_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      s_last_q    <= s_last_d;
      cout_q      <= cout_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign s_last    = s_last_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_xs3_serial_adder.sv
// Self-checking bench for xs3_serial_adder: directed cases followed by random
// operations, all checked against a decimal reference model.
module tb_xs3_serial_adder;

  localparam int unsigned MAXDIG = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       first = 1'b0;
  logic       last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] s;
  logic       s_last;
  logic       cout;
  logic       err;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [3:0] s;
    logic       sl;
    logic       co;
    logic       er;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: is an operation open, digits taken, carry, error seen.
  bit m_in_op = 1'b0;
  int m_cnt   = 0;
  int m_carry = 0;
  bit m_err   = 1'b0;

  always #5 clk = ~clk;

  xs3_serial_adder #(.MAXDIG(MAXDIG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .first     (first),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .s_last    (s_last),
    .cout      (cout),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic bit bad_code(input int d);
    return (d < 3) || (d > 12);
  endfunction

  // Decimal arithmetic for legal digits; raw biased rule for illegal ones.
  task automatic model_beat(input int ai, input int bi, input bit fi, input bit la);
    bit   start;
    int   cnt, cin, sum, sd, co;
    bit   e, fin;
    exp_t x;
    start = !m_in_op || fi;
    cnt   = start ? 0 : m_cnt;
    cin   = start ? 0 : m_carry;
    e     = (start ? 1'b0 : m_err) | bad_code(ai) | bad_code(bi);
    if (!bad_code(ai) && !bad_code(bi)) begin
      sum = (ai - 3) + (bi - 3) + cin;
      co  = sum / 10;
      sd  = (sum % 10) + 3;
    end else begin
      sum = ai + bi + cin;
      co  = (sum >= 16) ? 1 : 0;
      sd  = co ? ((sum - 16 + 3) % 16) : ((sum - 3 + 16) % 16);
    end
    fin  = la || (cnt == int'(MAXDIG) - 1);
    x.s  = 4'(sd);
    x.sl = fin;
    x.co = fin && (co == 1);
    x.er = fin && e;
    exp_q.push_back(x);
    if (fin) begin
      m_in_op = 1'b0; m_cnt = 0; m_carry = 0; m_err = 1'b0;
    end else begin
      m_in_op = 1'b1; m_cnt = cnt + 1; m_carry = co; m_err = e;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int ai, input int bi, input bit fi, input bit la, input bit rdy);
    bit acc = 1'b0;
    a = 4'(ai); b = 4'(bi); first = fi; last = la; in_valid = 1'b1;
    out_ready = rdy;
    for (int w = 0; w < 20; w++) begin
      #1 acc = in_ready;
      @(posedge clk);
      if (acc) model_beat(ai, bi, fi, la);
      @(negedge clk);
      if (acc) break;
      if (w >= 2) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    check("accept_timeout", acc, 1);
  endtask

  // Output scoreboard: every handshaken digit must match the next expectation.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("s", s, e.s);
        check("s_last", s_last, e.sl);
        check("cout", cout, e.co);
        check("err", err, e.er);
      end
    end
  end

  initial begin
    logic [3:0] hold_s;
    int len, ai, bi;
    bit fi;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_s_last", s_last, 0);
    check("rst_cout", cout, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Single digit 5+5 and 99+01.
    send(8, 8, 1, 1, 1);
    send(12, 4, 1, 0, 1);
    send(12, 3, 0, 1, 1);

    // Backpressure: hold one digit for 5 cycles, then let both through.
    repeat (2) @(negedge clk);
    send(5, 6, 1, 0, 0);
    hold_s = exp_q[0].s;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_s", s, hold_s);
    end
    @(negedge clk);
    send(7, 4, 0, 1, 1);

    // Invalid digit in a two-digit operation, then a clean operation.
    send(15, 5, 1, 0, 1);
    send(6, 7, 0, 1, 1);
    send(4, 4, 1, 1, 1);

    // Reset in the middle of an operation.
    send(12, 12, 1, 0, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_s", s, 0);
    @(negedge clk);
    rst = 1'b0;
    m_in_op = 1'b0; m_cnt = 0; m_carry = 0; m_err = 1'b0;
    send(3, 3, 1, 1, 1);

    // Forced last after MAXDIG digits; following beat must start afresh.
    for (int i = 0; i < 4; i++) send(12, 12, (i == 0), 0, 1);
    send(3, 3, 0, 1, 1);

    // Random operations with random backpressure and occasional abandonment.
    for (int op = 0; op < 40; op++) begin
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        ai = ($urandom % 8 == 0) ? $urandom_range(0, 15) : $urandom_range(3, 12);
        bi = ($urandom % 8 == 0) ? $urandom_range(0, 15) : $urandom_range(3, 12);
        fi = (i == 0) || ($urandom % 16 == 0);
        send(ai, bi, fi, (i == len - 1), ($urandom % 4) != 0);
      end
    end

    // Drain and confirm every expected digit was delivered once.
    out_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
